// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared RV32I control definitions: opcodes, ALUOp codes, per-stage control bundles.
// No logic, no latency; the bundles carry no flow control of their own.
// Consumers gate bundles to all-zero to express a bubble.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_RFN = 2'b10;
    localparam logic [1:0] ALU_IFN = 2'b11;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       link;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic link;
    } wb_ctrl_t;

    typedef struct packed {
        logic     branch;
        logic     mem_read;
        logic     mem_write;
        wb_ctrl_t wb;
    } mem_ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-side request and per-stage control outputs of the pipeline control unit.
// Outputs are registered per stage except stall_o/illegal_o, which are combinational.
// No handshake: the datapath honours stall_o by holding PC and IF/ID.
interface pipe_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
);
    logic                  id_valid;
    logic [6:0]            id_opcode;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  flush_i;
    logic                  stall_o;
    logic                  illegal_o;
    logic [ALUOP_W-1:0]    ex_alu_op;
    logic                  ex_alu_src;
    logic                  ex_jump;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_branch;
    logic                  mem_read;
    logic                  mem_write;
    logic                  wb_reg_write;
    logic                  wb_mem_to_reg;
    logic                  wb_link;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, flush_i,
        input  stall_o, illegal_o, ex_alu_op, ex_alu_src, ex_jump, ex_rd,
        input  mem_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, flush_i,
        output stall_o, illegal_o, ex_alu_op, ex_alu_src, ex_jump, ex_rd,
        output mem_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link
    );
endinterface

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Opcode to control-bundle table; also usable by a single-cycle core.
// Purely combinational, zero latency; no backpressure.
// Unknown opcodes (and jal/jalr when jumps are disabled) give a zero bundle and legal=0.
module ctrl_decode
    import rv_ctrl_pkg::*;
#(
    parameter bit EN_JUMP = 1'b1
) (
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       legal
);

    always_comb begin
        ctrl  = CTRL_NOP;
        legal = 1'b1;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_RFN;
            end
            OP_I: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_IFN;
            end
            OP_LOAD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_JAL, OP_JALR: begin
                if (EN_JUMP) begin
                    // jalr adds rs1 + imm, jal targets PC-relative so no immediate ALU operand
                    ctrl.alu_src   = (opcode == OP_JALR);
                    ctrl.reg_write = 1'b1;
                    ctrl.jump      = 1'b1;
                    ctrl.link      = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Registered RV32I control path: decode in ID, carried through ID/EX, EX/MEM, MEM/WB.
// Latency: ex_* 1 cycle, mem_* 2 cycles, wb_* 3 cycles after ID capture.
// Load-use hazard raises stall_o and injects a bubble into ID/EX; flush_i overrides stall.
module pipe_ctrl_unit
    import rv_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2,
    parameter bit EN_JUMP    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_unit_if.slave  pif
);

    ctrl_t                 dec_ctrl;
    logic                  dec_legal;
    ctrl_t                 id_ctrl;
    logic                  load_use;
    logic                  stall;
    logic                  insert_bubble;

    ctrl_t                 ex_ctrl;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    mem_ctrl_t             mem_q;
    wb_ctrl_t              wb_q;

    ctrl_decode #(.EN_JUMP(EN_JUMP)) u_decode (
        .opcode (pif.id_opcode),
        .ctrl   (dec_ctrl),
        .legal  (dec_legal)
    );

    always_comb begin
        id_ctrl = dec_ctrl;
        if (!pif.id_valid || !dec_legal) begin
            id_ctrl = CTRL_NOP;
        end
        if (pif.id_rd == '0) begin
            id_ctrl.reg_write = 1'b0;
        end
    end

    // Both sources are compared for every opcode; a false stall only costs a cycle.
    assign load_use = ex_ctrl.mem_read && (ex_rd_q != '0) && pif.id_valid &&
                      ((ex_rd_q == pif.id_rs1) || (ex_rd_q == pif.id_rs2));
    assign stall         = load_use && !pif.flush_i;
    assign insert_bubble = stall || pif.flush_i || !pif.id_valid || !dec_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl <= CTRL_NOP;
            ex_rd_q <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            ex_ctrl <= insert_bubble ? CTRL_NOP : id_ctrl;
            ex_rd_q <= insert_bubble ? '0 : pif.id_rd;
            mem_q   <= '{branch:    ex_ctrl.branch,
                         mem_read:  ex_ctrl.mem_read,
                         mem_write: ex_ctrl.mem_write,
                         wb:        '{reg_write:  ex_ctrl.reg_write,
                                      mem_to_reg: ex_ctrl.mem_to_reg,
                                      link:       ex_ctrl.link}};
            wb_q    <= mem_q.wb;
        end
    end

    assign pif.stall_o       = stall;
    assign pif.illegal_o     = pif.id_valid && !dec_legal;
    assign pif.ex_alu_op     = ALUOP_W'(ex_ctrl.alu_op);
    assign pif.ex_alu_src    = ex_ctrl.alu_src;
    assign pif.ex_jump       = ex_ctrl.jump;
    assign pif.ex_rd         = ex_rd_q;
    assign pif.mem_branch    = mem_q.branch;
    assign pif.mem_read      = mem_q.mem_read;
    assign pif.mem_write     = mem_q.mem_write;
    assign pif.wb_reg_write  = wb_q.reg_write;
    assign pif.wb_mem_to_reg = wb_q.mem_to_reg;
    assign pif.wb_link       = wb_q.link;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (jumps enabled / disabled with 3-bit ALUOp) share stimulus.
// Reference keeps the bundle captured in each of the last three cycles and looks them up by age.
module tb_pipe_ctrl_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.REG_ADDR_W(5), .ALUOP_W(2)) ifa ();
    pipe_ctrl_unit_if #(.REG_ADDR_W(5), .ALUOP_W(3)) ifb ();

    pipe_ctrl_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .EN_JUMP(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .pif(ifa.slave));
    pipe_ctrl_unit #(.REG_ADDR_W(5), .ALUOP_W(3), .EN_JUMP(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .pif(ifb.slave));

    assign ifb.id_valid  = ifa.id_valid;
    assign ifb.id_opcode = ifa.id_opcode;
    assign ifb.id_rs1    = ifa.id_rs1;
    assign ifb.id_rs2    = ifa.id_rs2;
    assign ifb.id_rd     = ifa.id_rd;
    assign ifb.flush_i   = ifa.flush_i;

    typedef struct packed {
        logic src, m2r, rw, mr, mw, br, jmp, lnk;
        logic [1:0] aop;
        logic [4:0] rd;
    } mb_t;

    // age 0 = captured last cycle (EX), 1 = MEM, 2 = WB
    mb_t ha[3];
    mb_t hb[3];

    logic [6:0] op_tab[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1101111, 7'b1100111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mb_t ref_decode(input bit en_jump, input logic v, input logic [6:0] op,
                                       input logic [4:0] rd, output logic ill);
        mb_t        m;
        logic [9:0] row;
        bit         ok;
        ok  = 1'b1;
        row = '0;
        case (op)
            7'b0110011: row = 10'b0_0_1_0_0_0_0_0_10;
            7'b0010011: row = 10'b1_0_1_0_0_0_0_0_11;
            7'b0000011: row = 10'b1_1_1_1_0_0_0_0_00;
            7'b0100011: row = 10'b1_0_0_0_1_0_0_0_00;
            7'b1100011: row = 10'b0_0_0_0_0_1_0_0_01;
            7'b1101111: begin row = 10'b0_0_1_0_0_0_1_1_00; ok = en_jump; end
            7'b1100111: begin row = 10'b1_0_1_0_0_0_1_1_00; ok = en_jump; end
            default:    ok = 1'b0;
        endcase
        m   = '0;
        ill = v && !ok;
        if (v && ok) begin
            {m.src, m.m2r, m.rw, m.mr, m.mw, m.br, m.jmp, m.lnk, m.aop} = row;
            m.rd = rd;
            if (rd == 5'd0) m.rw = 1'b0;
        end
        return m;
    endfunction

    function automatic logic ref_stall(input mb_t ex, input logic v, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic fl);
        return !fl && ex.mr && (ex.rd != 5'd0) && v && (ex.rd == rs1 || ex.rd == rs2);
    endfunction

    task automatic check_all(input logic sa, input logic ila, input logic sb, input logic ilb);
        chk("a_stall",    ifa.stall_o, sa);
        chk("a_illegal",  ifa.illegal_o, ila);
        chk("a_ex_alu_op", ifa.ex_alu_op, ha[0].aop);
        chk("a_ex_alu_src", ifa.ex_alu_src, ha[0].src);
        chk("a_ex_jump",  ifa.ex_jump, ha[0].jmp);
        chk("a_ex_rd",    ifa.ex_rd, ha[0].rd);
        chk("a_mem_branch", ifa.mem_branch, ha[1].br);
        chk("a_mem_read", ifa.mem_read, ha[1].mr);
        chk("a_mem_write", ifa.mem_write, ha[1].mw);
        chk("a_wb_reg_write", ifa.wb_reg_write, ha[2].rw);
        chk("a_wb_mem_to_reg", ifa.wb_mem_to_reg, ha[2].m2r);
        chk("a_wb_link",  ifa.wb_link, ha[2].lnk);
        chk("b_stall",    ifb.stall_o, sb);
        chk("b_illegal",  ifb.illegal_o, ilb);
        chk("b_ex_alu_op", ifb.ex_alu_op, {1'b0, hb[0].aop});
        chk("b_ex_alu_src", ifb.ex_alu_src, hb[0].src);
        chk("b_ex_jump",  ifb.ex_jump, hb[0].jmp);
        chk("b_ex_rd",    ifb.ex_rd, hb[0].rd);
        chk("b_mem_branch", ifb.mem_branch, hb[1].br);
        chk("b_mem_read", ifb.mem_read, hb[1].mr);
        chk("b_mem_write", ifb.mem_write, hb[1].mw);
        chk("b_wb_reg_write", ifb.wb_reg_write, hb[2].rw);
        chk("b_wb_mem_to_reg", ifb.wb_mem_to_reg, hb[2].m2r);
        chk("b_wb_link",  ifb.wb_link, hb[2].lnk);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic fl,
                        output logic stalled);
        mb_t  ma, mb;
        logic ila, ilb, sa, sb;
        ifa.id_valid  = v;
        ifa.id_opcode = op;
        ifa.id_rs1    = rs1;
        ifa.id_rs2    = rs2;
        ifa.id_rd     = rd;
        ifa.flush_i   = fl;
        ma = ref_decode(1'b1, v, op, rd, ila);
        mb = ref_decode(1'b0, v, op, rd, ilb);
        sa = ref_stall(ha[0], v, rs1, rs2, fl);
        sb = ref_stall(hb[0], v, rs1, rs2, fl);
        @(negedge clk);
        check_all(sa, ila, sb, ilb);
        @(posedge clk);
        ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = (sa || fl) ? mb_t'('0) : ma;
        hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = (sb || fl) ? mb_t'('0) : mb;
        #1;
        stalled = sa;
    endtask

    // Re-presents the instruction while the unit asks for a stall, as IF/ID would.
    task automatic issue(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic fl);
        logic s;
        int   n;
        n = 0;
        do begin
            step(v, op, rs1, rs2, rd, fl, s);
            n++;
        end while (s && n < 3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            ha[i] = '0;
            hb[i] = '0;
        end
    endtask

    initial begin
        clear_model();
        ifa.id_valid = 1'b0; ifa.id_opcode = '0; ifa.id_rs1 = '0;
        ifa.id_rs2 = '0; ifa.id_rd = '0; ifa.flush_i = 1'b0;

        // reset state
        @(negedge clk);
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // back-to-back independent lw, R, sw, beq
        issue(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5, 1'b0);
        issue(1'b1, 7'b0110011, 5'd2, 5'd3, 5'd4, 1'b0);
        issue(1'b1, 7'b0100011, 5'd6, 5'd8, 5'd0, 1'b0);
        issue(1'b1, 7'b1100011, 5'd9, 5'd10, 5'd0, 1'b0);
        idle(3);

        // load-use on rs2
        issue(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd7, 1'b0);
        issue(1'b1, 7'b0110011, 5'd2, 5'd7, 5'd8, 1'b0);
        idle(3);

        // load to x0 never stalls
        issue(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd0, 1'b0);
        issue(1'b1, 7'b0110011, 5'd0, 5'd3, 5'd8, 1'b0);
        idle(3);

        // flush coinciding with a load-use hazard
        issue(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd7, 1'b0);
        issue(1'b1, 7'b0110011, 5'd7, 5'd2, 5'd8, 1'b1);
        issue(1'b1, 7'b0010011, 5'd3, 5'd0, 5'd9, 1'b0);
        idle(3);

        // jal (illegal on the jump-less instance), jalr, flushed illegal opcode
        issue(1'b1, 7'b1101111, 5'd0, 5'd0, 5'd1, 1'b0);
        issue(1'b1, 7'b1100111, 5'd2, 5'd0, 5'd1, 1'b0);
        issue(1'b1, 7'b1111111, 5'd0, 5'd0, 5'd3, 1'b1);
        idle(3);

        // asynchronous reset with all stages full
        issue(1'b1, 7'b0000011, 5'd1, 5'd0, 5'd5, 1'b0);
        issue(1'b1, 7'b0110011, 5'd2, 5'd3, 5'd4, 1'b0);
        issue(1'b1, 7'b1100111, 5'd2, 5'd0, 5'd6, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        clear_model();
        chk("rst_ex_alu_op", ifa.ex_alu_op, 32'd0);
        chk("rst_ex_alu_src", ifa.ex_alu_src, 32'd0);
        chk("rst_ex_jump", ifa.ex_jump, 32'd0);
        chk("rst_ex_rd", ifa.ex_rd, 32'd0);
        chk("rst_mem_read", ifa.mem_read, 32'd0);
        chk("rst_wb_reg_write", ifa.wb_reg_write, 32'd0);
        chk("rst_wb_link", ifa.wb_link, 32'd0);
        chk("rst_stall", ifa.stall_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // randomized traffic with small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [6:0] op;
            int         k;
            k  = $urandom_range(0, 8);
            op = (k < 7) ? op_tab[k] : 7'($urandom);
            issue($urandom_range(0, 9) != 0, op, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
